// File: rtl/melody_pkg.sv
// Shared FSM encoding, beat code constants and ROM word layout for the melody sequencer.
package melody_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        LOAD,
        PLAY
    } seq_state_t;

    localparam logic [3:0] BEAT_END       = 4'd0;
    localparam logic [3:0] BEAT_WHOLE     = 4'd1;
    localparam logic [3:0] BEAT_HALF      = 4'd2;
    localparam logic [3:0] BEAT_QUARTER   = 4'd3;
    localparam logic [3:0] BEAT_EIGHTH    = 4'd4;
    localparam logic [3:0] BEAT_SIXTEENTH = 4'd5;

    localparam int REST_TONE = 0;

    // ROM word: tone in the upper field, 4-bit beat code in the low nibble.
    localparam int BEAT_LSB = 0;
    localparam int BEAT_W   = 4;
    localparam int TONE_LSB = 4;

endpackage

// File: rtl/melody_sequencer_note_timer.sv
// Loadable down-counter with freeze; zero flag marks the last cycle of a note.
module note_timer
    import melody_pkg::*;
#(
    parameter int CNT_W = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             hold,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (!hold && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/melody_sequencer.sv
// Song ROM sequencer driving the buzzer; build with MELODY_SEQ_LOOP_EN to repeat the song until stop.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int TONE_W = 4,
    parameter int CNT_W  = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [TONE_W+3:0] rom_data,
    output logic [3:0]        beat_code,
    input  logic [CNT_W-1:0]  beat_len,
    output logic [TONE_W-1:0] tone_code,
    output logic              tone_en,
    output logic              note_strobe,
    output logic              busy,
    output logic              done
);

    seq_state_t        state;
    logic [TONE_W-1:0] tone_latch;
    logic              tone_on;
    logic              timer_zero;
    logic              timer_load;
    logic              timer_hold;
    logic [CNT_W-1:0]  timer_value;
    logic              last_addr;
    logic              abort;
    logic              load_note;
    logic              song_end;

    assign last_addr = &rom_addr;
    assign abort     = stop && (state != IDLE);
    assign load_note = (state == LOAD) && !stop && !pause && (beat_len != '0);

    // Stop outranks end-of-song, and a paused cycle never ends the song.
    assign song_end = !stop && !pause &&
                      (((state == LOAD) && (beat_len == '0)) ||
                       ((state == PLAY) && timer_zero && last_addr));

    // An abort clears the counter so a later song starts from a clean timer.
    assign timer_load  = load_note || abort;
    assign timer_value = abort ? '0 : (beat_len - CNT_W'(1));
    assign timer_hold  = pause || (state != PLAY);

    note_timer #(
        .CNT_W(CNT_W)
    ) u_note_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (timer_load),
        .value(timer_value),
        .hold (timer_hold),
        .zero (timer_zero)
    );

    assign busy    = (state != IDLE);
    assign tone_en = tone_on && !pause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rom_addr    <= '0;
            beat_code   <= '0;
            tone_latch  <= '0;
            tone_code   <= '0;
            tone_on     <= 1'b0;
            note_strobe <= 1'b0;
            done        <= 1'b0;
        end else begin
            note_strobe <= 1'b0;
            done        <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                rom_addr  <= '0;
                tone_code <= '0;
                tone_on   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            state    <= FETCH;
                            rom_addr <= '0;
                        end
                    end
                    FETCH: begin
                        if (!pause) state <= WAIT_ROM;
                    end
                    WAIT_ROM: begin
                        if (!pause) begin
                            tone_latch <= rom_data[TONE_LSB +: TONE_W];
                            beat_code  <= rom_data[BEAT_LSB +: BEAT_W];
                            state      <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (load_note) begin
                            tone_code   <= tone_latch;
                            tone_on     <= (tone_latch != TONE_W'(REST_TONE));
                            note_strobe <= 1'b1;
                            state       <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (!pause && timer_zero && !last_addr) begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                            state    <= FETCH;
                        end
                    end
                    default: state <= IDLE;
                endcase

                // The previous tone keeps sounding into the next fetch when looping.
                if (song_end) begin
                    done     <= 1'b1;
                    rom_addr <= '0;
`ifdef MELODY_SEQ_LOOP_EN
                    if ((state == LOAD) && (rom_addr == '0)) begin
                        state     <= IDLE;
                        tone_code <= '0;
                        tone_on   <= 1'b0;
                    end else begin
                        state <= FETCH;
                    end
`else
                    state     <= IDLE;
                    tone_code <= '0;
                    tone_on   <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomised self-checking bench for melody_sequencer (default build, song does not loop).
module tb_melody_sequencer;

    localparam int ADDR_W = 8;
    localparam int TONE_W = 4;
    localparam int CNT_W  = 28;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              pause = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [TONE_W+3:0] rom_data;
    logic [3:0]        beat_code;
    logic [CNT_W-1:0]  beat_len;
    logic [TONE_W-1:0] tone_code;
    logic              tone_en;
    logic              note_strobe;
    logic              busy;
    logic              done;

    logic [7:0] rom [256];
    int         beat_tbl [16];
    int         n_checks = 0;
    int         n_errors = 0;
    int         strobe_cycles[$];
    int         done_cycle;

    always #5 clk = ~clk;

    // Song ROM with one cycle of read latency, beat decoder as a plain lookup.
    always @(posedge clk) rom_data <= rom[rom_addr];
    always_comb beat_len = CNT_W'(beat_tbl[beat_code]);

    melody_sequencer #(
        .ADDR_W(ADDR_W),
        .TONE_W(TONE_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .beat_code  (beat_code),
        .beat_len   (beat_len),
        .tone_code  (tone_code),
        .tone_en    (tone_en),
        .note_strobe(note_strobe),
        .busy       (busy),
        .done       (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic basicSetup();
        clearRom();
        for (int i = 0; i < 16; i++) beat_tbl[i] = 0;
        beat_tbl[3] = 10;
        beat_tbl[4] = 6;
        rom[0] = 8'h33;
        rom[1] = 8'h54;
        rom[2] = 8'h00;
    endtask

    task automatic idleCheck(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_strobe", note_strobe, 0);
        end
    endtask

    // Model: note k strobes at base 4 + sum(len+3); each paused busy cycle delays all later events by one.
    task automatic applyStimulus(input int pause_at, input int pause_len, input bit rand_start,
                                 input int stop_note);
        int   ev_base[$];
        int   ev_tone[$];
        int   b, addr, len, ei, nonp, p, cur_tone, n_strobe, stop_cyc, limit;
        logic [7:0] w;
        bit   pause_now, exp_strobe, exp_done, finished;
        b = 4;
        addr = 0;
        forever begin
            w = rom[addr];
            len = beat_tbl[w[3:0]];
            if (len == 0) begin
                ev_base.push_back(b);
                ev_tone.push_back(-1);
                break;
            end
            ev_base.push_back(b);
            ev_tone.push_back(int'(w[7:4]));
            if (addr == 255) begin
                ev_base.push_back(b + len);
                ev_tone.push_back(-1);
                break;
            end
            b += len + 3;
            addr++;
        end
        limit = ev_base[ev_base.size()-1] + pause_len + 20;
        strobe_cycles.delete();
        done_cycle = -1;
        ei = 0; nonp = 0; cur_tone = 0; n_strobe = 0; stop_cyc = -1; finished = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        for (int c = 1; c <= limit && !finished; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            stop = 1'b0;
            pause_now = (pause_at > 0) && (c >= pause_at) && (c < pause_at + pause_len);
            pause = pause_now;
            #1;
            if (stop_cyc > 0 && c == stop_cyc + 1) begin
                checkOutput("stop_busy", busy, 0);
                checkOutput("stop_tone_en", tone_en, 0);
                checkOutput("stop_tone_code", tone_code, 0);
                checkOutput("stop_rom_addr", rom_addr, 0);
                checkOutput("stop_done", done, 0);
                finished = 1;
            end else begin
                p = 1 + nonp;
                exp_strobe = 0;
                exp_done = 0;
                if (ei < ev_base.size() && ev_base[ei] == p) begin
                    if (ev_tone[ei] < 0) exp_done = 1;
                    else begin
                        exp_strobe = 1;
                        cur_tone = ev_tone[ei];
                    end
                    ei++;
                end
                if (note_strobe) strobe_cycles.push_back(c);
                if (done) done_cycle = c;
                checkOutput("note_strobe", note_strobe, exp_strobe);
                checkOutput("done", done, exp_done);
                if (exp_done) begin
                    checkOutput("end_busy", busy, 0);
                    checkOutput("end_tone_en", tone_en, 0);
                    checkOutput("end_tone_code", tone_code, 0);
                    checkOutput("end_rom_addr", rom_addr, 0);
                    finished = 1;
                end else begin
                    checkOutput("busy", busy, 1);
                    checkOutput("tone_code", tone_code, cur_tone);
                    checkOutput("tone_en", tone_en, (cur_tone != 0) && !pause_now);
                end
                if (exp_strobe) begin
                    if (n_strobe == stop_note) stop_cyc = c + 4;
                    n_strobe++;
                end
                if (c == stop_cyc) stop = 1'b1;
                else if (rand_start && !finished && $urandom_range(0, 3) == 0) start = 1'b1;
                if (!pause_now) nonp++;
            end
        end
        start = 1'b0;
        stop = 1'b0;
        pause = 1'b0;
        if (!finished) checkOutput("timeout", 0, 1);
    endtask

    initial begin
        logic [3:0] code;
        int         n, last, k, pat;
        clearRom();
        for (int i = 0; i < 16; i++) beat_tbl[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_tone_en", tone_en, 0);
        checkOutput("rst_tone_code", tone_code, 0);
        checkOutput("rst_rom_addr", rom_addr, 0);
        checkOutput("rst_beat_code", beat_code, 0);
        checkOutput("rst_strobe", note_strobe, 0);
        checkOutput("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCheck(2);

        $display("[TB] basic play");
        basicSetup();
        applyStimulus(0, 0, 1'b0, -1);
        checkOutput("basic_strobe_count", strobe_cycles.size(), 2);
        if (strobe_cycles.size() == 2) begin
            checkOutput("basic_strobe0", strobe_cycles[0], 4);
            checkOutput("basic_strobe1", strobe_cycles[1], 17);
        end
        checkOutput("basic_done_cycle", done_cycle, 26);
        idleCheck(3);

        $display("[TB] pause for 7 cycles");
        applyStimulus(8, 7, 1'b0, -1);
        if (strobe_cycles.size() == 2) checkOutput("pause_strobe1", strobe_cycles[1], 24);
        checkOutput("pause_done_cycle", done_cycle, 33);
        idleCheck(3);

        $display("[TB] stop during second note, then replay");
        applyStimulus(0, 0, 1'b0, 1);
        checkOutput("stop_no_done", done_cycle, -1);
        idleCheck(4);
        applyStimulus(0, 0, 1'b0, -1);
        checkOutput("replay_done_cycle", done_cycle, 26);
        idleCheck(2);

        $display("[TB] rest and invalid code");
        rom[0] = 8'h03;
        rom[1] = 8'h00;
        applyStimulus(0, 0, 1'b0, -1);
        checkOutput("rest_done_cycle", done_cycle, 17);
        rom[0] = 8'h69;
        applyStimulus(0, 0, 1'b0, -1);
        checkOutput("invalid_done_cycle", done_cycle, 4);
        idleCheck(2);

        $display("[TB] reset mid-note");
        basicSetup();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        checkOutput("pre_rst_tone_en", tone_en, 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_tone_en", tone_en, 0);
        checkOutput("arst_tone_code", tone_code, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_rom_addr", rom_addr, 0);
        checkOutput("arst_beat_code", beat_code, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCheck(10);
        applyStimulus(0, 0, 1'b0, -1);
        checkOutput("post_rst_done_cycle", done_cycle, 26);

        $display("[TB] randomised songs");
        for (int it = 0; it < 20; it++) begin
            clearRom();
            for (int i = 0; i < 16; i++) beat_tbl[i] = (i >= 1 && i <= 5) ? int'($urandom_range(5, 12)) : 0;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                code = 4'($urandom_range(1, 5));
                rom[i] = {4'($urandom_range(0, 15)), code};
            end
            k = $urandom_range(0, 10);
            code = (k == 0) ? 4'd0 : 4'(k + 5);
            rom[n] = {4'($urandom_range(0, 15)), code};
            last = 4 + n * 10;
            pat = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, last - 1)) : 0;
            applyStimulus(pat, (pat > 0) ? int'($urandom_range(1, 8)) : 0, 1'b1, -1);
            idleCheck(2);
        end

        $display("[TB] full ROM, wrap via end-of-song");
        for (int i = 0; i < 256; i++) rom[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(1, 5))};
        applyStimulus(100, 5, 1'b1, -1);
        checkOutput("full_strobe_count", strobe_cycles.size(), 256);
        idleCheck(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Steps through a song ROM of {tone, beat} entries and drives the buzzer tone generator.
- Sends each entry's 4-bit beat code to the beat decoder and receives the decoded cycle count back.
- Holds each note for that many cycles, then fetches the next entry.
- Sits between the top-level game control (start/stop/pause, e.g. on game start or death) and the buzzer datapath.

Parameters:
- ADDR_W, 8, song ROM address width.
- TONE_W, 4, tone code width; code 0 = rest.
- CNT_W, 28, width of the decoded beat length.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse; begins the song at address 0 when idle
- stop  in  1  level; aborts playback
- pause  in  1  level; freezes the note counter and mutes output
- rom_addr  out  ADDR_W  song ROM address
- rom_data  in  TONE_W+4  ROM word; [TONE_W+3:4] = tone, [3:0] = beat code; synchronous read, 1-cycle latency
- beat_code  out  4  registered beat code, to the beat decoder
- beat_len  in  CNT_W  decoded cycle count from the decoder (combinational from beat_code); 0 = invalid/end
- tone_code  out  TONE_W  tone to the buzzer generator
- tone_en  out  1  buzzer enable
- note_strobe  out  1  1-cycle pulse when a new note is loaded
- busy  out  1  high in any state other than IDLE
- done  out  1  1-cycle pulse when the song ends normally

Behaviour:
- Reset (async, rst_n=0): state IDLE; rom_addr=0, beat_code=0, tone_code=0, tone_en=0, note_strobe=0, busy=0, done=0; counter=0.
- States: IDLE, FETCH, WAIT_ROM, LOAD, PLAY.
- IDLE:
  - start=1 and stop=0 -> FETCH, with rom_addr=0.
  - start is ignored in every other state.
- FETCH: rom_addr is stable; -> WAIT_ROM.
- WAIT_ROM: register rom_data tone into a tone latch and rom_data beat into beat_code; -> LOAD.
- LOAD (beat_len now valid):
  - beat_len==0 (end marker or unknown code) -> end-of-song handling.
  - Otherwise: counter = beat_len-1; tone_code = latched tone; tone_en = (tone!=0); note_strobe=1; -> PLAY.
- PLAY:
  - counter decrements each cycle while pause=0.
  - counter==0 with pause=0: if rom_addr is all-ones, end-of-song; else rom_addr+1 -> FETCH.
- Note timing:
  - tone_code and tone_en hold their values through the next note's FETCH/WAIT_ROM, so there are no gaps.
  - Consecutive note_strobes are exactly beat_len+3 cycles apart.
- End-of-song (without the optional feature): -> IDLE; tone_code=0, tone_en=0, rom_addr=0, done=1 for one cycle.
- pause:
  - While pause=1, tone_en is forced to 0 and the counter is frozen.
  - In FETCH/WAIT_ROM/LOAD, pause stalls the FSM in its current state.
  - Deasserting pause resumes with no lost or extra cycles.
- stop:
  - stop=1 in any non-IDLE state -> IDLE next cycle; tone_code=0, tone_en=0, rom_addr=0, no done pulse.
  - stop has priority over pause and over end-of-song.
- Simultaneous start and stop in IDLE: stay IDLE.
- rst_n asserted mid-note: all outputs go to their reset values immediately.
- Width rules: counter is CNT_W bits; rom_addr wraps only via end-of-song, never silently.

Optional Feature:
- Macro MELODY_SEQ_LOOP_EN.
- When defined, end-of-song does not go to IDLE: it pulses done, sets rom_addr=0 and goes -> FETCH. The last tone is held until the first note reloads, so the song repeats until stop.
- An end marker at address 0 still goes to IDLE, to avoid an infinite empty loop.
- When undefined, behaviour is as specified under end-of-song above.

Decomposition:
- Shared package melody_pkg:
  - FSM state encoding.
  - Beat code constants (WHOLE=1, HALF=2, QUARTER=3, EIGHTH=4, SIXTEENTH=5, END=0).
  - Rest tone code 0.
  - ROM word field offsets.
- One natural sub-module, note_timer: loadable down-counter with freeze (load, value, hold, zero flag), CNT_W wide.

Test Plan:
- Basic play: ROM {tone3/beat3, tone5/beat4, 0/0}; bench drives beat_len=10 for code 3 and 6 for code 4.
  - Expect note_strobe at t0 and t0+13, tone_code 3 then 5.
  - Expect done pulse with tone_en=0 at t0+13+6+3.
- Rest: entry {tone0, beat3}.
  - Expect tone_en=0 for 10 cycles and tone_code=0, while note_strobe still fires.
- Pause: assert pause for 7 cycles mid-note.
  - Expect tone_en=0 during the pause.
  - Expect the next note_strobe delayed by exactly 7 cycles.
- Stop: assert stop 4 cycles into the second note.
  - Expect IDLE next cycle: busy=0, tone_en=0, rom_addr=0, no done pulse.
  - Then start replays from address 0.
- Invalid code: beat code 9 gives beat_len=0.
  - Expect immediate end-of-song and done pulse.
  - With MELODY_SEQ_LOOP_EN defined, expect rom_addr=0 and the first note replays.
- Reset mid-PLAY: drop rst_n.
  - Expect all outputs 0 asynchronously.
  - After release, start is required to play again.
